// File: rtl/covid_nios2_qsys_0_oci_trace_fifo.sv
// Nios II OCI trace capture buffer: stores each dct_count change as a tagged
// {count, data} word in a FIFO, with freeze/end handling and status counters.
//
// state      | meaning
// CAPTURE    | trace events are written into the FIFO
// FROZEN     | test_ending seen; no writes, reads still drain
// ENDED      | test_has_ended seen; no writes, reads still drain
module covid_nios2_qsys_0_oci_trace_fifo #(
    parameter int DATA_W  = 30,
    parameter int COUNT_W = 4,
    parameter int DEPTH   = 16,
    parameter int MODE    = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           dct_buffer,
    input  logic [COUNT_W-1:0]          dct_count,
    input  logic                        test_ending,
    input  logic                        test_has_ended,
    input  logic                        rd_req,
    output logic [DATA_W+COUNT_W-1:0]   rd_data,
    output logic                        rd_valid,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        empty,
    output logic                        full,
    output logic                        overflow,
    output logic                        frozen,
    output logic                        ended,
    output logic [15:0]                 capture_total
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = DATA_W + COUNT_W;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_FROZEN  = 2'd1,
        ST_ENDED   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] prev_count_q, prev_count_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               overflow_q, overflow_d;
    logic               frozen_q, frozen_d;
    logic               ended_q, ended_d;
    logic [WW-1:0]      rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [15:0]        total_q, total_d;

    logic [WW-1:0]      mem_q [DEPTH];
    logic               mem_we;
    logic [WW-1:0]      mem_wdata;

    logic               evt;
    logic               cap_evt;
    logic               is_full;
    logic               rd_ok;
    logic               lvl_inc;

    assign mem_wdata = {dct_count, dct_buffer};

    always_comb begin
        state_d      = state_q;
        prev_count_d = dct_count;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        rd_data_d    = rd_data_q;
        total_d      = total_q;
        mem_we       = 1'b0;
        lvl_inc      = 1'b0;

        evt     = (dct_count != prev_count_q);
        // test_has_ended wins over a coincident event; test_ending does not
        cap_evt = (state_q == ST_CAPTURE) && evt && !test_has_ended;
        is_full = (level_q == LW'(DEPTH));
        rd_ok   = rd_req && (level_q != '0);

        rd_valid_d = rd_ok;
        if (rd_ok) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end

        if (cap_evt) begin
            if (total_q != 16'hFFFF) begin
                total_d = total_q + 1'b1;
            end
            if (!is_full || rd_ok) begin
                mem_we   = 1'b1;
                lvl_inc  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else if (MODE == 1) begin
                // overwrite: oldest entry is discarded, occupancy unchanged
                mem_we     = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                overflow_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (lvl_inc && !rd_ok) begin
            level_d = level_q + 1'b1;
        end else if (!lvl_inc && rd_ok) begin
            level_d = level_q - 1'b1;
        end

        if (test_has_ended) begin
            state_d = ST_ENDED;
        end else if (state_q == ST_CAPTURE && test_ending) begin
            state_d = ST_FROZEN;
        end

        frozen_d = (state_d != ST_CAPTURE);
        ended_d  = (state_d == ST_ENDED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CAPTURE;
            prev_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            frozen_q     <= 1'b0;
            ended_q      <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            frozen_q     <= frozen_d;
            ended_q      <= ended_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            total_q      <= total_d;
        end
    end

    // storage needs no reset; pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[wr_ptr_q] <= mem_wdata;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign level         = level_q;
    assign empty         = (level_q == '0);
    assign full          = (level_q == LW'(DEPTH));
    assign overflow      = overflow_q;
    assign frozen        = frozen_q;
    assign ended         = ended_q;
    assign capture_total = total_q;

endmodule

// File: doc/covid_nios2_qsys_0_oci_trace_fifo.md
# covid_nios2_qsys_0_oci_trace_fifo

Parametrised OCI debug-trace capture buffer for the Nios II core. It watches the OCI trace word/count pair for count changes and stores each change as a tagged word in an on-chip FIFO. Host logic can drain the FIFO through a simple read port. It honours the test_ending/test_has_ended protocol with freeze and end states, and reports fill level, overflow and event totals.

## Interface
Parameters:
- DATA_W, 30, width of dct_buffer
- COUNT_W, 4, width of dct_count
- DEPTH, 16, FIFO entries; power of two, 2..256
- MODE, 0, 0 = drop new words when full; 1 = overwrite oldest when full

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- dct_buffer  in  DATA_W  trace data word
- dct_count  in  COUNT_W  trace count; any change marks a new event
- test_ending  in  1  level; requests freeze of capture
- test_has_ended  in  1  level; moves block to final state
- rd_req  in  1  pop request
- rd_data  out  DATA_W+COUNT_W  popped word {count, data}
- rd_valid  out  1  one-cycle pulse qualifying rd_data
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- overflow  out  1  sticky; set on any drop or overwrite
- frozen  out  1  high in FROZEN and ENDED
- ended  out  1  high in ENDED
- capture_total  out  16  saturating count of detected events, including dropped ones

## Operation
- Reset (reset high at a clock edge) sets the following:
  - state CAPTURE; pointers 0; prev_count 0.
  - level 0, empty 1, full 0, overflow 0, frozen 0, ended 0.
  - rd_valid 0, rd_data 0, capture_total 0.
  - Reset mid-operation discards all contents.
- Event detection:
  - event = (dct_count != prev_count).
  - prev_count <= dct_count every cycle, in every state.
- State machine:
  - CAPTURE: events are written.
  - CAPTURE -> FROZEN when test_ending = 1.
  - CAPTURE or FROZEN -> ENDED when test_has_ended = 1. This has priority over test_ending.
  - FROZEN and ENDED exit only via reset.
  - FROZEN and ENDED perform no writes, but reads still work.
  - capture_total counts only in CAPTURE.
- Write, in CAPTURE on an event:
  - Stores {dct_count, dct_buffer} at wr_ptr.
  - If not full, or full with rd_req accepted the same cycle: normal write.
  - If full with no read, MODE=0: word is dropped and overflow is set.
  - If full with no read, MODE=1: word is written, the oldest word is discarded (rd_ptr advances), level stays DEPTH, and overflow is set.
- Read:
  - rd_req with !empty pops the oldest word.
  - rd_req with empty is ignored: no pop, rd_valid stays 0, no flag.
- Simultaneous read and write: both occur and level is unchanged. With DEPTH = 1 entry in use, the read returns the old word.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is computed separately (not from pointer difference alone) so that full and empty are unambiguous.
- capture_total saturates at 0xFFFF.

## Timing
- An event in cycle t is stored at the t edge. level, empty and full reflect it in cycle t+1.
- An event in the same cycle as the first test_ending is still captured. Freeze takes effect from t+1.
- An event in the same cycle as test_has_ended is not captured.
- Read latency is 1: rd_req accepted in cycle t gives rd_data and rd_valid in t+1.
- rd_data holds its value until the next valid pop.
- Back-to-back rd_req every cycle drains one word per cycle.
- frozen and ended are registered and assert in the cycle after their triggering input.

## Test plan
- Reset, then dct_count 0→1→2→3 on consecutive cycles with dct_buffer = 0x100+count. Required: level 3, capture_total 3. Three rd_req give {1,0x101}, {2,0x102}, {3,0x103}, with rd_valid one cycle after each request.
- MODE=0, DEPTH=4, 6 events. Required: level 4, overflow 1, capture_total 6, reads return the first 4 words.
- MODE=1, DEPTH=4, 6 events. Required: level 4, overflow 1, reads return events 3..6.
- Full FIFO with event and rd_req in the same cycle (MODE=0). Required: level stays 4, overflow 0, the oldest word is read out, the new word is present at the tail.
- test_ending together with an event, followed by 3 more events. Required: only the first is stored. frozen=1 from the next cycle. Reads still drain. test_has_ended then gives ended=1.
- Reset asserted while level=3. Required: the next cycle shows level 0 and empty 1. rd_req gives rd_valid 0.
